// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised LSB-first UART receiver with a valid/ready word output.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits (parity_err otherwise tied 0).
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 rx_s;
    logic [CW-1:0]        count;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 stop_bad;
    logic                 tick, last_bit, done, good, perr;

    always_ff @(posedge clock or posedge reset)
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign tick     = count == LAST;
    assign last_bit = state == DATA ? bit_idx == BW'(DATA_BITS - 1)
                    : state == STOP ? bit_idx == BW'(STOP_BITS - 1) : 1'b1;
    assign done     = state == STOP && tick && last_bit;
    assign good     = done && !stop_bad && rx_s;

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (!rx_s) state_n = START;
            START:     if (count == HALF) state_n = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:      if (tick && last_bit) state_n = PARITY;
            PARITY:    if (tick) state_n = STOP;
`else
            DATA:      if (tick && last_bit) state_n = STOP;
`endif
            STOP:      if (done) state_n = good ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        busy      = state != IDLE;
        frame_err = done && !good;
    end

    // bit counter restarts at each sample; START only runs to the mid-bit point
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            stop_bad <= 1'b0;
        end else begin
            count    <= (state == IDLE || state == WAIT_HIGH || tick || (state == START && count == HALF))
                        ? '0 : count + CW'(1);
            bit_idx  <= state == IDLE ? '0 : tick ? (last_bit ? '0 : bit_idx + BW'(1)) : bit_idx;
            stop_bad <= state == IDLE ? 1'b0 : stop_bad | (state == STOP && tick && !rx_s);
            if (state == DATA && tick) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clock or posedge reset)
        if (reset)                          par_bit <= 1'b0;
        else if (state == PARITY && tick)   par_bit <= rx_s;

    assign perr = (^{shreg, par_bit}) != PARITY_ODD;
`else
    assign perr = PARITY_ODD & 1'b0;
`endif

    // a completing frame may reuse the output slot only if it is empty or being accepted now
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= good && data_valid && !data_ready;
            if (good && (!data_valid || data_ready)) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                parity_err <= perr;
            end else if (data_ready) begin
                data_valid <= 1'b0;
                parity_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed scoreboard bench for uart_rx_param.
// With UART_RX_PARITY_EN defined it runs the 16-clock, 7-bit, 2-stop parity configuration.
module tb_uart_rx_param;
`ifdef UART_RX_PARITY_EN
    localparam int CPB = 16, DB = 7, SB = 2, NP = 1;
`else
    localparam int CPB = 868, DB = 8, SB = 1, NP = 0;
`endif
    localparam int HALF = CPB / 2 - 1;
    // edges from driving the start bit to data_valid rising (2 sync flops + IDLE detect)
    localparam int LAT = 4 + HALF + (DB + NP + SB) * CPB;

    logic          clock = 1'b0;
    logic          reset, rx, data_ready;
    logic [DB-1:0] data_out;
    logic          data_valid, frame_err, overrun, parity_err, busy;

    int            cyc = 0, vectors = 0, miscompares = 0, seen = 0;
    int            acc_cnt = 0, valid_cnt = 0, fe_cnt = 0, ov_cnt = 0;
    int            rise_cyc = -1, fe_cyc = -1, ov_cyc = -1;
    logic          valid_d = 1'b0;
    logic [DB:0]   acc_word = '0;
    logic [DB:0]   exp_q[$];

    uart_rx_param #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(DB),
        .STOP_BITS(SB),
        .SYNC_STAGES(2),
        .PARITY_ODD(1'b0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx(rx),
        .data_out(data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .parity_err(parity_err),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        valid_d <= data_valid;
        if (data_valid) valid_cnt <= valid_cnt + 1;
        if (data_valid && !valid_d) rise_cyc <= cyc;
        if (data_valid && data_ready) begin
            acc_word <= {parity_err, data_out};
            acc_cnt  <= acc_cnt + 1;
        end
        if (frame_err) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
        if (overrun) begin
            ov_cnt <= ov_cnt + 1;
            ov_cyc <= cyc;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        cycles(CPB);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic stop_v, output int k);
        k = cyc;
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        if (NP == 1) send_bit(p);
        for (int i = 0; i < SB; i++) send_bit(stop_v);
    endtask

    task automatic wait_word(input string tag);
        logic [DB:0] e;
        e = 'x;
        for (int i = 0; i < 4 * CPB && acc_cnt == seen; i++) cycles(1);
        chk({tag, "_arrived"}, acc_cnt - seen, 1);
        if (acc_cnt != seen) begin
            seen = acc_cnt;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            chk(tag, 32'(acc_word), 32'(e));
        end
    endtask

    initial begin
        int k, fe0, ov0, va0;
        reset = 1'b1;
        rx = 1'b1;
        data_ready = 1'b1;
        cycles(3);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_ovr", 32'(overrun), 0);
        chk("rst_perr", 32'(parity_err), 0);
        reset = 1'b0;
        cycles(5);
`ifdef UART_RX_PARITY_EN
        exp_q.push_back({1'b1, 7'h55});
        send_frame(7'h55, 1'b1, 1'b1, k);
        wait_word("t6_bad_parity");
        chk("t6_latency", rise_cyc - k, LAT);
        chk("t6_perr_cleared", 32'(parity_err), 0);
        exp_q.push_back({1'b0, 7'h55});
        send_frame(7'h55, 1'b0, 1'b1, k);
        wait_word("t6_good_parity");
        chk("t6_latency2", rise_cyc - k, LAT);
        chk("t6_no_ferr", fe_cnt, 0);
        chk("t6_no_ovr", ov_cnt, 0);
`else
        va0 = valid_cnt;
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b1, k);
        wait_word("t1_word");
        chk("t1_latency", rise_cyc - k, LAT);
        chk("t1_valid_cycles", valid_cnt - va0, 1);
        chk("t1_no_ferr", fe_cnt, 0);
        chk("t1_no_ovr", ov_cnt, 0);

        va0 = valid_cnt;
        rx = 1'b0;
        k = cyc;
        cycles(200);
        rx = 1'b1;
        cycles(HALF + 3 - 200);
        chk("t2_busy_hold", 32'(busy), 1);
        cycles(1);
        chk("t2_busy_drop", 32'(busy), 0);
        chk("t2_no_valid", valid_cnt - va0, 0);
        exp_q.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b1, k);
        wait_word("t2_word");

        va0 = valid_cnt;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, k);
        cycles(3000);
        chk("t3_ferr_cnt", fe_cnt - fe0, 1);
        chk("t3_ferr_time", fe_cyc - k, LAT - 1);
        chk("t3_busy_break", 32'(busy), 1);
        chk("t3_no_valid", valid_cnt - va0, 0);
        rx = 1'b1;
        cycles(2);
        chk("t3_busy_wait", 32'(busy), 1);
        cycles(1);
        chk("t3_busy_idle", 32'(busy), 0);
        chk("t3_ferr_once", fe_cnt - fe0, 1);

        data_ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back({1'b0, 8'h11});
        send_frame(8'h11, 1'b0, 1'b1, k);
        send_frame(8'h22, 1'b0, 1'b1, k);
        cycles(5);
        chk("t4_ovr_cnt", ov_cnt - ov0, 1);
        chk("t4_ovr_time", ov_cyc - k, LAT);
        chk("t4_valid_held", 32'(data_valid), 1);
        chk("t4_data_held", 32'(data_out), 'h11);
        chk("t4_no_accept", acc_cnt - seen, 0);
        data_ready = 1'b1;
        cycles(1);
        chk("t4_valid_clear", 32'(data_valid), 0);
        wait_word("t4_word");

        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx = 1'b0;
        cycles(CPB);
        rx = 1'b1;
        cycles(3 * CPB);
        chk("t5_busy_mid", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("t5_rst_data", 32'(data_out), 0);
        chk("t5_rst_valid", 32'(data_valid), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_flags", 32'({frame_err, overrun, parity_err}), 0);
        cycles(2);
        reset = 1'b0;
        cycles(5);
        chk("t5_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        exp_q.push_back({1'b0, 8'h5A});
        send_frame(8'h5A, 1'b0, 1'b1, k);
        wait_word("t5_word");
`endif
        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
